// File: rtl/mc_ctrl_fsm_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mc_ctrl_fsm_if #(
  parameter int ST_W = 4
);
  logic [5:0]      op;
  logic            zero;
  logic            mem_ready;
  logic            pc_en;
  logic            iord;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            mem_to_reg;
  logic            reg_dst;
  logic            reg_write;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic [1:0]      pc_source;
  logic            illegal_op;
  logic [ST_W-1:0] state;

  modport master (
    input  op, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: 3-5 cycles/insn, +1 cycle per mem_ready-low cycle in FETCH/MEMRD/MEMWR.
// Optional bne support is enabled by defining MC_CTRL_BNE_EN.
module mc_ctrl_fsm #(
  parameter int ST_W       = 4,
  parameter bit FETCH_WAIT = 1'b1
) (
  input logic           clk,
  input logic           reset,
  mc_ctrl_fsm_if.master bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADR    = 4'd2,
    MEMRD     = 4'd3,
    MEMWB     = 4'd4,
    MEMWR     = 4'd5,
    EXEC      = 4'd6,
    ALUWB     = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11
`ifdef MC_CTRL_BNE_EN
    , BRANCH_NE = 4'd12
`endif
  } state_t;

  state_t     state_q, state_d;
  logic       iord_c, mem_read_c, mem_write_c, ir_write_c;
  logic       mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;
  logic       pc_write, branch, branch_ne, illegal_c;
  logic       fetch_done;

  assign fetch_done = (FETCH_WAIT == 1'b0) | bus.mem_ready;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = FETCH;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_dst_c    = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    pc_source_c  = 2'b00;
    pc_write     = 1'b0;
    branch       = 1'b0;
    branch_ne    = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        if (fetch_done) begin
          ir_write_c = 1'b1;
          pc_write   = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        alu_src_b_c = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = BRANCH_NE;
`endif
          default:      illegal_c = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord_c     = 1'b1;
        mem_read_c = 1'b1;
        state_d    = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
      end
      // Address and strobe stay asserted for the whole wait so the write is stable.
      MEMWR: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
        state_d     = bus.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
      end
      BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_source_c = 2'b01;
        branch      = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      BRANCH_NE: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_source_c = 2'b01;
        branch_ne   = 1'b1;
      end
`endif
      JUMP: begin
        pc_write    = 1'b1;
        pc_source_c = 2'b10;
      end
      ADDI_EX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  // While reset is held, present FETCH decode with every strobe masked off.
  assign bus.iord       = reset & iord_c;
  assign bus.mem_read   = reset & mem_read_c;
  assign bus.mem_write  = reset & mem_write_c;
  assign bus.ir_write   = reset & ir_write_c;
  assign bus.mem_to_reg = reset & mem_to_reg_c;
  assign bus.reg_dst    = reset & reg_dst_c;
  assign bus.reg_write  = reset & reg_write_c;
  assign bus.alu_src_a  = reset & alu_src_a_c;
  assign bus.alu_src_b  = reset ? alu_src_b_c : 2'b01;
  assign bus.alu_op     = reset ? alu_op_c    : 2'b00;
  assign bus.pc_source  = reset ? pc_source_c : 2'b00;
  assign bus.illegal_op = reset & illegal_c;
  assign bus.pc_en      = reset & (pc_write | (branch & bus.zero) | (branch_ne & ~bus.zero));
  assign bus.state      = ST_W'(state_q);
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: per-instruction expected phase traces built from opcode class and stall counts.
module tb_mc_ctrl_fsm;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [13:0] RESET_ROW = 14'b0000_0000_01_00_00;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mc_ctrl_fsm_if #(.ST_W(4)) bus ();

  mc_ctrl_fsm #(.ST_W(4), .FETCH_WAIT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    case (o)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
`ifdef MC_CTRL_BNE_EN
      OP_BNE: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Fields: iord mem_read mem_write ir_write mem_to_reg reg_dst reg_write alu_src_a | alu_src_b | alu_op | pc_source
  function automatic logic [13:0] ctrl_row(input int s);
    case (s)
      0:       return 14'b0101_0000_01_00_00;
      1:       return 14'b0000_0000_11_00_00;
      2:       return 14'b0000_0001_10_00_00;
      3:       return 14'b1100_0000_00_00_00;
      4:       return 14'b0000_1010_00_00_00;
      5:       return 14'b1010_0000_00_00_00;
      6:       return 14'b0000_0001_00_10_00;
      7:       return 14'b0000_0110_00_00_00;
      8, 12:   return 14'b0000_0001_00_01_01;
      9:       return 14'b0000_0000_00_00_10;
      10:      return 14'b0000_0001_10_00_00;
      11:      return 14'b0000_0010_00_00_00;
      default: return 14'b0;
    endcase
  endfunction

  function automatic logic [13:0] observed();
    return {bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source};
  endfunction

  task automatic cycle_check(input string tag, input int exp_s, input logic mr, input logic z,
                             input logic exp_ill);
    logic [13:0] row;
    logic        exp_pc_en;
    row = ctrl_row(exp_s);
    if (exp_s == 0 && !mr) row[10] = 1'b0;
    case (exp_s)
      0:       exp_pc_en = mr;
      8:       exp_pc_en = z;
      9:       exp_pc_en = 1'b1;
      12:      exp_pc_en = !z;
      default: exp_pc_en = 1'b0;
    endcase
    chk({tag, ".state"}, 32'(bus.state), 32'(exp_s));
    chk({tag, ".ctrl"}, 32'(observed()), 32'(row));
    chk({tag, ".pc_en"}, 32'(bus.pc_en), 32'(exp_pc_en));
    chk({tag, ".illegal"}, 32'(bus.illegal_op), 32'(exp_ill));
    chk({tag, ".rd_wr"}, 32'(bus.mem_read & bus.mem_write), 32'd0);
    chk({tag, ".rw_ir"}, 32'(bus.reg_write & bus.ir_write), 32'd0);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, ".rst_ctrl"}, 32'(observed()), 32'(RESET_ROW));
    chk({tag, ".rst_pc_en"}, 32'(bus.pc_en), 32'd0);
    chk({tag, ".rst_ill"}, 32'(bus.illegal_op), 32'd0);
  endtask

  // Entered and left at a falling edge: drive, settle, check, advance one cycle.
  task automatic step(input string tag, input logic mr, input logic z, input logic [5:0] opc,
                      input int exp_s, input logic exp_ill);
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.op        = opc;
    #1;
    cycle_check(tag, exp_s, mr, z, exp_ill);
    @(negedge clk);
  endtask

  // fs/ds = cycles mem_ready is held low in FETCH / in the data-memory phase.
  // zmode 0/1 forces zero, anything else randomizes it every cycle.
  task automatic run_insn(input string tag, input logic [5:0] opc, input int fs, input int ds,
                          input int zmode);
    int   sq[$];
    logic wq[$];
    logic z;
    for (int i = 0; i <= fs; i++) begin sq.push_back(0); wq.push_back(i == fs); end
    sq.push_back(1); wq.push_back(1'($urandom));
    if (is_legal(opc)) begin
      case (opc)
        OP_LW: begin
          sq.push_back(2); wq.push_back(1'($urandom));
          for (int i = 0; i <= ds; i++) begin sq.push_back(3); wq.push_back(i == ds); end
          sq.push_back(4); wq.push_back(1'($urandom));
        end
        OP_SW: begin
          sq.push_back(2); wq.push_back(1'($urandom));
          for (int i = 0; i <= ds; i++) begin sq.push_back(5); wq.push_back(i == ds); end
        end
        OP_RTYPE: begin
          sq.push_back(6); wq.push_back(1'($urandom));
          sq.push_back(7); wq.push_back(1'($urandom));
        end
        OP_BEQ: begin sq.push_back(8); wq.push_back(1'($urandom)); end
        OP_J:   begin sq.push_back(9); wq.push_back(1'($urandom)); end
        OP_ADDI: begin
          sq.push_back(10); wq.push_back(1'($urandom));
          sq.push_back(11); wq.push_back(1'($urandom));
        end
        OP_BNE: begin sq.push_back(12); wq.push_back(1'($urandom)); end
        default: ;
      endcase
    end
    for (int k = 0; k < sq.size(); k++) begin
      if (zmode == 0)      z = 1'b0;
      else if (zmode == 1) z = 1'b1;
      else                 z = 1'($urandom);
      step(tag, wq[k], z, (sq[k] == 0) ? 6'($urandom) : opc, sq[k],
           (sq[k] == 1) && !is_legal(opc));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] opc;
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    bus.op = 6'd0;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("reset.state", 32'(bus.state), 32'd0);
      reset_check("reset");
    end
    @(negedge clk);
    reset = 1'b1;

    run_insn("rtype", OP_RTYPE, 0, 0, 2);
    run_insn("lw_stall", OP_LW, 0, 3, 2);
    run_insn("lw", OP_LW, 0, 0, 2);
    run_insn("sw_stall", OP_SW, 1, 2, 2);
    run_insn("beq_taken", OP_BEQ, 0, 0, 1);
    run_insn("beq_not", OP_BEQ, 0, 0, 0);
    run_insn("jump", OP_J, 0, 0, 2);
    run_insn("addi", OP_ADDI, 2, 0, 2);
    run_insn("illegal", 6'b111111, 0, 0, 2);
    run_insn("bne_taken", OP_BNE, 0, 0, 0);
    run_insn("bne_not", OP_BNE, 0, 0, 1);

    // Reset landing in the middle of a stalled store.
    step("abort", 1'b1, 1'b0, OP_SW, 0, 1'b0);
    step("abort", 1'b1, 1'b0, OP_SW, 1, 1'b0);
    step("abort", 1'b1, 1'b0, OP_SW, 2, 1'b0);
    step("abort", 1'b0, 1'b0, OP_SW, 5, 1'b0);
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort.pre_state", 32'(bus.state), 32'd5);
    reset_check("abort.pre");
    @(negedge clk); #1;
    chk("abort.post_state", 32'(bus.state), 32'd0);
    reset_check("abort.post");
    @(negedge clk);
    reset = 1'b1;
    run_insn("after_abort", OP_SW, 0, 0, 2);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0: opc = OP_LW;
        1: opc = OP_SW;
        2: opc = OP_RTYPE;
        3: opc = OP_BEQ;
        4: opc = OP_J;
        5: opc = OP_ADDI;
        6: opc = OP_BNE;
        default: begin
          opc = 6'($urandom);
          while (is_legal(opc) || opc == OP_BNE) opc = 6'($urandom);
        end
      endcase
      run_insn("rand", opc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS control unit for the Lab8 datapath (PC, unified memory, IR, register file, ALU).
- Sequences each instruction through fetch, decode, execute, memory and writeback by driving the datapath mux selects and write enables.
- Stalls on a memory-ready handshake so the same controller works with single-cycle or wait-stated memory.

Parameters:
- ST_W, 4, width of state/debug output.
- FETCH_WAIT, 1, 1 = honour mem_ready on instruction fetch; 0 = fetch completes in one cycle.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- op  input  6  IR[31:26] opcode
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access complete this cycle
- pc_en  output  1  PC load enable = pc_write | (branch & zero)
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load enable
- mem_to_reg  output  1  writeback select: 1 = MDR
- reg_dst  output  1  destination select: 1 = rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 1 = register A
- alu_src_b  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sext imm<<2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- state  output  ST_W  current state, for debug

Behaviour:
- Moore FSM; all outputs decode from the registered state, except pc_en, which combines the state-decoded pc_write/branch with zero.
- Reset (reset==0 at a clk edge): state=FETCH. Outputs during reset take the FETCH-state values with strobes suppressed, i.e. all 0 except alu_src_b=01.
- Reset asserted mid-instruction aborts that instruction with no further writes.
- Default for every output is 0.
- States (encoding 0..11) and asserted outputs:
  - FETCH: mem_read, alu_src_b=01, alu_op=00. When mem_ready (or FETCH_WAIT=0), also ir_write and pc_write with pc_source=00, then go to DECODE; otherwise stay in FETCH with ir_write/pc_write low.
  - DECODE: alu_src_b=11, alu_op=00. Next state by op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EX
    - any other -> FETCH, with illegal_op=1 for that one cycle
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: iord=1, mem_read=1. Wait until mem_ready, then -> MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
  - MEMWR: iord=1, mem_write=1. Hold until mem_ready, then -> FETCH. The write is held stable for the whole wait.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_source=01. -> FETCH.
  - JUMP: pc_write=1, pc_source=10. -> FETCH.
  - ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
- Latencies with mem_ready tied to 1:
  - R-type 4 cycles, addi 4, lw 5, sw 4, beq 3, j 3.
  - Each cycle mem_ready is low adds one cycle in FETCH, MEMRD or MEMWR.
- op is sampled only in DECODE and MEMADR; the IR is stable in those states.
- Never assert mem_read and mem_write together.
- Never assert reg_write and ir_write together.
- Unused state encodings (12..15) -> FETCH on the next edge, all outputs 0.

Optional Feature:
- Macro MC_CTRL_BNE_EN.
- When defined: op 000101 (bne) -> BRANCH_NE state. Outputs match BRANCH, except pc_en = branch & ~zero. 3 cycles.
- When undefined: 000101 is illegal (illegal_op pulse, return to FETCH).

Test Plan:
- reset=0 for 2 cycles, mem_ready=1 -> state=0; all strobes 0. reset=1 -> first edge gives FETCH with mem_read=1, ir_write=1, pc_en=1.
- op=000000, mem_ready=1 -> state sequence 0,1,6,7,0. reg_write=1 and reg_dst=1 only in ALUWB; alu_op=10 in EXEC.
- op=100011, mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, iord=1 throughout, then MEMWB with reg_write=1, mem_to_reg=1. Total 8 cycles.
- op=000100: zero=1 -> pc_en=1 in BRANCH; zero=0 -> pc_en=0. Both return to FETCH after 3 cycles.
- op=111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH. No reg_write or mem_write. Repeat with op=000101 in a build without MC_CTRL_BNE_EN.
- reset=0 asserted during MEMWR -> next state FETCH, mem_write drops at that edge, and no reg_write follows.
